mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the four-bank main memory between the instruction-cache and data-cache controllers.
//  Grants one requester at a time and holds the grant for a whole burst (line fill or dirty writeback).
//  Issues single-word accesses only to non-busy banks and routes read-return strobes back to the issuer.
//  Sits between the two cache FSMs and the banked memory in the memory system.
// PARAMETERS
//  AW      16  address width; bank select = addr[2:1]
//  DW      16  data width
//  RD_LAT  2   cycles from accepted read to mem_rdata valid (>=1)
// PORTS
//  clk         in   1   clock
//  rst         in   1   asynchronous reset, active-high
//  req0/req1   in   1   requester 0 (I-cache) / 1 (D-cache) wants an access this cycle
//  wr0/wr1     in   1   1 = write, 0 = read; qualified by reqN
//  addr0/addr1 in   AW  word address of access
//  wdata0/1    in   DW  write data
//  last0/last1 in   1   this access is the final one of the burst
//  gnt0/gnt1   out  1   access of requester N issued to memory this cycle
//  rvalid0/1   out  1   mem_rdata belongs to requester N this cycle
//  rdata       out  DW  read data (direct copy of mem_rdata)
//  mem_addr    out  AW  memory address
//  mem_wdata   out  DW  memory write data
//  mem_wr      out  1   memory write strobe
//  mem_rd      out  1   memory read strobe
//  mem_rdata   in   DW  memory read data
//  mem_busy    in   4   per-bank busy from memory
//  mem_stall   in   1   memory global stall
// BEHAVIOUR
//  - Reset: state=IDLE, prio=0 (req0 favoured), return pipe cleared; gntN, rvalidN, mem_wr, mem_rd = 0;
//    mem_addr, mem_wdata = 0 while no owner. Reset mid-burst drops ownership and discards pending rvalids.
//  - States: IDLE, OWN0, OWN1.
//  - IDLE: no memory strobes. Only req0 -> OWN0; only req1 -> OWN1; both -> OWN(prio); neither -> IDLE.
//    Arbitration costs exactly 1 cycle; no access issues in IDLE.
//  - OWNn: mem_addr/mem_wdata driven from requester n. Issue when reqn & ~mem_stall & ~mem_busy[addrn[2:1]]:
//    mem_wr=wrn, mem_rd=~wrn, gntn=1 (same cycle, combinational). Otherwise no strobes, gntn=0 (requester holds).
//  - OWNn exit: issued access with lastn=1 -> IDLE, prio = ~n. reqn=0 in OWNn (abort) -> IDLE, prio = ~n, no strobe.
//  - Other requester is never granted while OWNn; its req is ignored until IDLE.
//  - Read return: each issued read pushes {1,id} into an RD_LAT-deep shift register; rvalid[id]=1 exactly
//    RD_LAT cycles after its gnt. Writes push {0,x}. Back-to-back reads yield back-to-back rvalids.
//  - rvalid0 and rvalid1 are mutually exclusive; gnt0 and gnt1 are mutually exclusive; mem_wr & mem_rd never both 1.
//  - Burst may have 1..N accesses; a one-access burst (last=1 on first issue) returns to IDLE next cycle.
//  - Ownership change while reads in flight is legal; rvalids follow issuing id, not current owner.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: adds outputs wait_cnt0, wait_cnt1 (16b each): increment every cycle reqN=1 and
//    gntN=0 (includes arbitration cycle and bank/stall blocking); saturate at 16'hFFFF; cleared by rst.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  arb_pkg: state encodings (ARB_IDLE, ARB_OWN0, ARB_OWN1), requester ids (REQ_ICACHE=0, REQ_DCACHE=1),
//    bank-select field constants.
//  Sub-module arb_rd_pipe: RD_LAT-deep {valid,id} shift register with async reset, outputs rvalid0/rvalid1.
//  State and prio registers with async active-high reset; issue logic combinational.
// TESTING
//  1 req0 read burst addr 16'h0100,0102,0104,0106 (last on 4th), banks free -> OWN0 after 1 cycle, 4 consecutive
//    gnt0, mem_rd each, rvalid0 on cycles gnt+2, then IDLE; gnt1 never asserted.
//  2 req0 and req1 both assert in IDLE after reset -> OWN0 first; after req0 last, req1 still high -> OWN1 next.
//  3 OWN1 write to 16'h0202 with mem_busy=4'b0010 for 3 cycles -> gnt1=0, no mem_wr for 3 cycles; issues on 4th.
//  4 OWN0 mid-burst, req0 drops -> IDLE next cycle, prio=1, no strobe; earlier in-flight read still gives rvalid0.
//  5 rst pulsed 1 cycle after a read issue -> all outputs 0 immediately, no rvalid appears afterwards.
//  6 (MEM_ARB_PERF_EN) req1 held 5 cycles while OWN0 -> wait_cnt1=5+1; force saturation -> holds 16'hFFFF.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared encodings for the I-cache/D-cache memory arbiter: FSM states, requester ids
// and the bank-select field of a word address.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    localparam int unsigned N_BANKS  = 4;
    localparam int unsigned BANK_W   = 2;
    localparam int unsigned BANK_LSB = 1;
    localparam int unsigned BANK_MSB = 2;

    // Bank index of a word address; caller passes the low address bits only.
    function automatic logic [BANK_W-1:0] bank_sel(input logic [BANK_MSB:0] addr_lo);
        return addr_lo[BANK_MSB:BANK_LSB];
    endfunction

endpackage

// File: rtl/arb_rd_pipe.sv
// Read-return tracker: RD_LAT-deep {valid,id} shift register that steers the
// memory read-data strobe back to whichever requester issued the read.
module arb_rd_pipe
    import arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_vld,
    input  logic push_id,
    output logic rvalid0,
    output logic rvalid1
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] id_q,  id_d;

    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        vld_d[0] = push_vld;
        id_d[0]  = push_id;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign rvalid0 = vld_q[RD_LAT-1] & (id_q[RD_LAT-1] == REQ_ICACHE);
    assign rvalid1 = vld_q[RD_LAT-1] & (id_q[RD_LAT-1] == REQ_DCACHE);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester banked-memory arbiter holding the grant for a whole burst.
// Optional MEM_ARB_PERF_EN adds saturating per-requester wait counters.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic               wr0,
    input  logic               wr1,
    input  logic [AW-1:0]      addr0,
    input  logic [AW-1:0]      addr1,
    input  logic [DW-1:0]      wdata0,
    input  logic [DW-1:0]      wdata1,
    input  logic               last0,
    input  logic               last1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               rvalid0,
    output logic               rvalid1,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_wr,
    output logic               mem_rd,
    input  logic [DW-1:0]      mem_rdata,
    input  logic [N_BANKS-1:0] mem_busy,
    input  logic               mem_stall
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]        wait_cnt0,
    output logic [15:0]        wait_cnt1
`endif
);

    arb_state_e state_q, state_d;
    logic       prio_q,  prio_d;
    logic       bank_free0, bank_free1;

    assign bank_free0 = ~mem_busy[bank_sel(addr0[BANK_MSB:0])];
    assign bank_free1 = ~mem_busy[bank_sel(addr1[BANK_MSB:0])];
    assign rdata      = mem_rdata;

    // Arbitration, burst ownership and same-cycle issue.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ARB_IDLE: begin
                if (req0 && req1) begin
                    state_d = (prio_q == REQ_DCACHE) ? ARB_OWN1 : ARB_OWN0;
                end else if (req0) begin
                    state_d = ARB_OWN0;
                end else if (req1) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0: begin
                mem_addr  = addr0;
                mem_wdata = wdata0;
                if (!req0) begin
                    state_d = ARB_IDLE;
                    prio_d  = REQ_DCACHE;
                end else if (!mem_stall && bank_free0) begin
                    gnt0   = 1'b1;
                    mem_wr = wr0;
                    mem_rd = ~wr0;
                    if (last0) begin
                        state_d = ARB_IDLE;
                        prio_d  = REQ_DCACHE;
                    end
                end
            end
            ARB_OWN1: begin
                mem_addr  = addr1;
                mem_wdata = wdata1;
                if (!req1) begin
                    state_d = ARB_IDLE;
                    prio_d  = REQ_ICACHE;
                end else if (!mem_stall && bank_free1) begin
                    gnt1   = 1'b1;
                    mem_wr = wr1;
                    mem_rd = ~wr1;
                    if (last1) begin
                        state_d = ARB_IDLE;
                        prio_d  = REQ_ICACHE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            prio_q  <= REQ_ICACHE;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Only reads enter the return pipe; the id is the issuer, not the later owner.
    arb_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .push_vld (mem_rd),
        .push_id  (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1)
    );

`ifdef MEM_ARB_PERF_EN
    logic [15:0] wait_cnt0_q, wait_cnt0_d;
    logic [15:0] wait_cnt1_q, wait_cnt1_d;

    always_comb begin
        wait_cnt0_d = wait_cnt0_q;
        wait_cnt1_d = wait_cnt1_q;
        if (req0 && !gnt0 && (wait_cnt0_q != 16'hFFFF)) begin
            wait_cnt0_d = wait_cnt0_q + 16'd1;
        end
        if (req1 && !gnt1 && (wait_cnt1_q != 16'hFFFF)) begin
            wait_cnt1_d = wait_cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt0_q <= '0;
            wait_cnt1_q <= '0;
        end else begin
            wait_cnt0_q <= wait_cnt0_d;
            wait_cnt1_q <= wait_cnt1_d;
        end
    end

    assign wait_cnt0 = wait_cnt0_q;
    assign wait_cnt1 = wait_cnt1_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, wr0, wr1, last0, last1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, mem_rd, mem_stall;
    logic [3:0]  mem_busy;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] wait_cnt0, wait_cnt1;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .wr0       (wr0),
        .wr1       (wr1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .last0     (last0),
        .last1     (last1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy),
        .mem_stall (mem_stall)
`ifdef MEM_ARB_PERF_EN
        ,
        .wait_cnt0 (wait_cnt0),
        .wait_cnt1 (wait_cnt1)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: current owner (-1 = none), favoured requester, read returns due.
    int own  = -1;
    int prio = 0;
    int cyc  = 0;
    int due_q[$];
    int rid_q[$];
    int wc[2];
    int last_g[2];
    int dut_rv_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: predict, compare at negedge, advance the model, return at posedge+1.
    task automatic cycle();
        logic [1:0]  r, w, l;
        logic [15:0] a[2];
        logic [15:0] d[2];
        int          eg[2];
        int          erv[2];
        int          erd, ewr, bank;
        logic [15:0] eaddr, ewd;
        @(negedge clk);
        r = {req1, req0};  w = {wr1, wr0};  l = {last1, last0};
        a[0] = addr0;  a[1] = addr1;  d[0] = wdata0;  d[1] = wdata1;
        eg[0] = 0;  eg[1] = 0;  erv[0] = 0;  erv[1] = 0;
        erd = 0;  ewr = 0;  eaddr = 16'h0;  ewd = 16'h0;
        if (!rst) begin
            if (own >= 0) begin
                eaddr = a[own];
                ewd   = d[own];
                bank  = (int'(a[own]) >> 1) % 4;
                if (r[own] && !mem_stall && !mem_busy[bank]) begin
                    eg[own] = 1;
                    if (w[own]) ewr = 1; else erd = 1;
                end
            end
            foreach (due_q[i]) if (due_q[i] == cyc) erv[rid_q[i]] = 1;
        end
        check_eq("gnt0",      32'(gnt0),      32'(eg[0]));
        check_eq("gnt1",      32'(gnt1),      32'(eg[1]));
        check_eq("mem_rd",    32'(mem_rd),    32'(erd));
        check_eq("mem_wr",    32'(mem_wr),    32'(ewr));
        check_eq("mem_addr",  32'(mem_addr),  32'(eaddr));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(ewd));
        check_eq("rvalid0",   32'(rvalid0),   32'(erv[0]));
        check_eq("rvalid1",   32'(rvalid1),   32'(erv[1]));
        check_eq("rdata",     32'(rdata),     32'(mem_rdata));
`ifdef MEM_ARB_PERF_EN
        check_eq("wait_cnt0", 32'(wait_cnt0), 32'(wc[0]));
        check_eq("wait_cnt1", 32'(wait_cnt1), 32'(wc[1]));
`endif
        dut_rv_cnt += int'(rvalid0) + int'(rvalid1);
        if (rst) begin
            own = -1;  prio = 0;  wc[0] = 0;  wc[1] = 0;
            due_q.delete();  rid_q.delete();
        end else begin
            for (int i = 0; i < 2; i++)
                if (r[i] && eg[i] == 0 && wc[i] < 65535) wc[i]++;
            while (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                void'(rid_q.pop_front());
            end
            if (erd != 0) begin
                due_q.push_back(cyc + RD_LAT);
                rid_q.push_back(own);
            end
            if (own < 0) begin
                if (r[0] && r[1]) own = prio;
                else if (r[0])    own = 0;
                else if (r[1])    own = 1;
            end else if (!r[own] || (eg[own] != 0 && l[own])) begin
                prio = 1 - own;
                own  = -1;
            end
        end
        last_g[0] = eg[0];
        last_g[1] = eg[1];
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0;  req1 = 0;  wr0 = 0;  wr1 = 0;  last0 = 0;  last1 = 0;
        addr0 = 16'h0;  addr1 = 16'h0;  wdata0 = 16'h0;  wdata1 = 16'h0;
        mem_busy = 4'h0;  mem_stall = 0;  mem_rdata = 16'h0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    initial begin
        int idx, first_k, gcnt, order[2], nord, rv_before;
        rst = 1;
        idle_inputs();
        #1;
        reset_dut();

        // Four-beat read burst from the I-cache.
        req0 = 1;  wr0 = 0;  addr0 = 16'h0100;  last0 = 0;
        idx = 0;  first_k = -1;  gcnt = 0;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            mem_rdata = 16'($urandom);
            cycle();
            gcnt += last_g[1];
            if (last_g[0] != 0) begin
                if (first_k < 0) first_k = k;
                idx++;
                addr0 = 16'h0100 + 16'(2 * idx);
                last0 = (idx == 3);
            end
        end
        req0 = 0;  last0 = 0;
        check_eq("t1_beats", 32'(idx), 32'd4);
        check_eq("t1_first_gnt_cycle", 32'(first_k), 32'd1);
        check_eq("t1_gnt1_count", 32'(gcnt), 32'd0);
        for (int k = 0; k < 4; k++) cycle();

        // Simultaneous requests after reset: I-cache first, then D-cache.
        reset_dut();
        req0 = 1;  req1 = 1;  last0 = 1;  last1 = 1;  addr0 = 16'h0010;  addr1 = 16'h0022;
        nord = 0;  order[0] = -1;  order[1] = -1;
        for (int k = 0; k < 12 && nord < 2; k++) begin
            cycle();
            if (last_g[0] != 0) begin order[nord] = 0; nord++; req0 = 0; end
            if (last_g[1] != 0) begin order[nord] = 1; nord++; req1 = 0; end
        end
        idle_inputs();
        check_eq("t2_first_owner", 32'(order[0]), 32'd0);
        check_eq("t2_second_owner", 32'(order[1]), 32'd1);
        cycle();

        // D-cache write blocked by a busy bank for three cycles.
        req1 = 1;  wr1 = 1;  addr1 = 16'h0202;  wdata1 = 16'hBEEF;  last1 = 1;  mem_busy = 4'b0010;
        cycle();
        gcnt = 0;
        for (int k = 0; k < 3; k++) begin cycle(); gcnt += last_g[1]; end
        check_eq("t3_blocked_gnts", 32'(gcnt), 32'd0);
        mem_busy = 4'b0000;
        cycle();
        check_eq("t3_issue_gnt1", 32'(last_g[1]), 32'd1);
        idle_inputs();
        cycle();

        // Abort mid-burst; the earlier read still returns and prio flips to the D-cache.
        req0 = 1;  wr0 = 0;  addr0 = 16'h0300;  last0 = 0;
        cycle();
        cycle();
        check_eq("t4_first_read", 32'(last_g[0]), 32'd1);
        req0 = 0;
        cycle();
        check_eq("t4_abort_no_gnt", 32'(last_g[0]), 32'd0);
        cycle();
        req0 = 1;  req1 = 1;  last0 = 1;  last1 = 1;
        cycle();
        cycle();
        check_eq("t4_prio_gnt1", 32'(last_g[1]), 32'd1);
        idle_inputs();
        cycle();
        cycle();

        // Reset right after a read issue swallows its return.
        req0 = 1;  wr0 = 0;  addr0 = 16'h0400;  last0 = 0;
        cycle();
        cycle();
        rst = 1;  req0 = 0;
        cycle();
        rst = 0;
        rv_before = dut_rv_cnt;
        for (int k = 0; k < RD_LAT + 3; k++) cycle();
        check_eq("t5_no_rvalid", 32'(dut_rv_cnt - rv_before), 32'd0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            req0   = ($urandom % 5) != 0;
            req1   = ($urandom % 5) != 0;
            wr0    = 1'($urandom);
            wr1    = 1'($urandom);
            addr0  = 16'($urandom);
            addr1  = 16'($urandom);
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            last0  = ($urandom % 4) == 0;
            last1  = ($urandom % 4) == 0;
            mem_busy  = (($urandom % 3) == 0) ? 4'($urandom) : 4'h0;
            mem_stall = ($urandom % 8) == 0;
            mem_rdata = 16'($urandom);
            rst       = ($urandom % 300) == 0;
            cycle();
        end
        rst = 0;
        idle_inputs();
        cycle();

`ifdef MEM_ARB_PERF_EN
        // Wait counters: D-cache starved behind a long I-cache burst, then saturation.
        reset_dut();
        req0 = 1;  wr0 = 1;  last0 = 0;  req1 = 1;  wr1 = 0;  last1 = 1;
        for (int k = 0; k < 6; k++) cycle();
        check_eq("t6_wait_cnt1", 32'(wait_cnt1), 32'd6);
        for (int k = 0; k < 65540; k++) cycle();
        check_eq("t6_wait_sat", 32'(wait_cnt1), 32'hFFFF);
        idle_inputs();
        cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
